reg_file_swc: RTL and testbench

//  Parametrised successor register file for the datapath: 2 async read ports,
//  1 sync write port, single-cycle SWAP of two entries, and a sequential

---
 rtl/reg_file_swc.sv | 118 +++++++++++
 tb/tb_reg_file_swc.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_swc.sv
// reg_file_swc
//   Register file with two combinational read ports, one synchronous write
//   port, a single-cycle swap of two entries, and a CLEAR sweep that zeroes
//   one entry per clock while busy is high.
//
// Parameters
//   DW        data width in bits
//   PW        address width; depth = 2**PW entries
//   ZERO_REG  1: entry 0 is hard-wired to zero
//
// Ports
//   clk        in   clock, state updates on posedge
//   rst_n      in   asynchronous active-low reset (clears all entries)
//   wr_en      in   write enable
//   wr_addr    in   [PW-1:0] write address
//   dat_in     in   [DW-1:0] write data
//   swap_en    in   exchange core[rd_addrA] and core[rd_addrB]
//   clr_req    in   start CLEAR sweep
//   rd_addrA   in   [PW-1:0] read port A address / swap operand A
//   rd_addrB   in   [PW-1:0] read port B address / swap operand B
//   datA_out   out  [DW-1:0] read data A (combinational)
//   datB_out   out  [DW-1:0] read data B (combinational)
//   busy       out  high while the CLEAR sweep runs
//
// Build option
//   REG_FILE_BYPASS_EN  forwards dat_in to a read port addressing the entry
//                       being written in the same cycle.
module reg_file_swc #(
  parameter int DW       = 8,
  parameter int PW       = 4,
  parameter int ZERO_REG = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [PW-1:0] wr_addr,
  input  logic [DW-1:0] dat_in,
  input  logic          swap_en,
  input  logic          clr_req,
  input  logic [PW-1:0] rd_addrA,
  input  logic [PW-1:0] rd_addrB,
  output logic [DW-1:0] datA_out,
  output logic [DW-1:0] datB_out,
  output logic          busy
);

  localparam int DEPTH = 1 << PW;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t        state;
  logic [PW-1:0] clr_cnt;
  logic [DW-1:0] core     [DEPTH];
  logic [DW-1:0] core_nxt [DEPTH];

  // Next contents of every entry. Swap reads only pre-edge values, and the
  // write is applied afterwards so it wins on an overlapping address.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      core_nxt[i] = core[i];
      if (state == CLEAR) begin
        if (clr_cnt == PW'(i)) core_nxt[i] = '0;
      end else if (!clr_req) begin
        if (swap_en && (rd_addrA != rd_addrB)) begin
          if (rd_addrA == PW'(i))      core_nxt[i] = core[rd_addrB];
          else if (rd_addrB == PW'(i)) core_nxt[i] = core[rd_addrA];
        end
        if (wr_en && (wr_addr == PW'(i))) core_nxt[i] = dat_in;
      end
      if ((ZERO_REG != 0) && (i == 0)) core_nxt[i] = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) core[i] <= '0;
      state   <= IDLE;
      clr_cnt <= '0;
      busy    <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) core[i] <= core_nxt[i];
      case (state)
        IDLE: begin
          if (clr_req) begin
            state   <= CLEAR;
            clr_cnt <= '0;
            busy    <= 1'b1;
          end
        end
        CLEAR: begin
          // Counter wraps to 0 as the last entry is cleared.
          clr_cnt <= clr_cnt + PW'(1);
          if (clr_cnt == PW'(DEPTH - 1)) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef REG_FILE_BYPASS_EN
  // Forward only when the write will actually land at the next edge.
  logic fwd;
  assign fwd = wr_en && (state == IDLE) && !clr_req &&
               !((ZERO_REG != 0) && (wr_addr == '0));
  assign datA_out = (fwd && (rd_addrA == wr_addr)) ? dat_in : core[rd_addrA];
  assign datB_out = (fwd && (rd_addrB == wr_addr)) ? dat_in : core[rd_addrB];
`else
  assign datA_out = core[rd_addrA];
  assign datB_out = core[rd_addrB];
`endif

endmodule

// File: tb/tb_reg_file_swc.sv
`timescale 1ns/100ps
module tb_reg_file_swc;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en, swap_en, clr_req;
  logic [3:0] wr_addr, rd_addrA, rd_addrB;
  logic [7:0] dat_in;
  logic [7:0] datA, datB, zdatA, zdatB;
  logic       busy, zbusy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_file_swc #(.DW(8), .PW(4), .ZERO_REG(0)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .dat_in(dat_in),
    .swap_en(swap_en), .clr_req(clr_req), .rd_addrA(rd_addrA), .rd_addrB(rd_addrB),
    .datA_out(datA), .datB_out(datB), .busy(busy)
  );

  reg_file_swc #(.DW(8), .PW(4), .ZERO_REG(1)) dut_z (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .dat_in(dat_in),
    .swap_en(swap_en), .clr_req(clr_req), .rd_addrA(rd_addrA), .rd_addrB(rd_addrB),
    .datA_out(zdatA), .datB_out(zdatB), .busy(zbusy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; dat_in = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    wr(4'd1, 8'h12);
    wr(4'd8, 8'h34);
    wr(4'd15, 8'h56);
    rd_addrA = 4'd8;
    #1;
    checks++;
    if (datA !== 8'h34) begin
      errors++; $display("FAIL pre_reset_rd8: got %h expected 34", datA);
    end
    rst_n = 1'b0;
    #0.5;
    for (int i = 0; i < 16; i++) begin
      rd_addrA = 4'(i);
      #0.1;
      checks++;
      if (datA !== 8'h00) begin
        errors++; $display("FAIL reset_entry%0d: got %h expected 00", i, datA);
      end
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy: got %b expected 0", busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_write_swap();
    wr(4'd3, 8'hA5);
    wr(4'd9, 8'h3C);
    rd_addrA = 4'd3; rd_addrB = 4'd9; swap_en = 1'b1;
    step();
    swap_en = 1'b0;
    checks++;
    if (datA !== 8'h3C) begin
      errors++; $display("FAIL swap_A3: got %h expected 3C", datA);
    end
    checks++;
    if (datB !== 8'hA5) begin
      errors++; $display("FAIL swap_B9: got %h expected A5", datB);
    end
    wr(4'd5, 8'h77);
    rd_addrA = 4'd5; rd_addrB = 4'd5; swap_en = 1'b1;
    step();
    swap_en = 1'b0;
    checks++;
    if (datA !== 8'h77) begin
      errors++; $display("FAIL swap_same5: got %h expected 77", datA);
    end
  endtask

  task automatic test_clear();
    for (int i = 0; i < 16; i++) wr(4'(i), 8'hFF);
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    // write attempt held during the whole sweep
    wr_en = 1'b1; wr_addr = 4'd0; dat_in = 8'hAB;
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (busy !== 1'b1) begin
        errors++; $display("FAIL clr_busy_c%0d: got %b expected 1", k, busy);
      end
      rd_addrA = 4'(k);
      rd_addrB = 4'((k + 1) % 16);
      #0.5;
      if (k < 15) begin
        checks++;
        if (datB !== 8'hFF) begin
          errors++; $display("FAIL clr_pending%0d: got %h expected FF", k + 1, datB);
        end
      end
      step();
      if (k == 15) wr_en = 1'b0;
      #0.5;
      checks++;
      if (datA !== 8'h00) begin
        errors++; $display("FAIL clr_entry%0d: got %h expected 00", k, datA);
      end
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL clr_busy_end: got %b expected 0", busy);
    end
    rd_addrA = 4'd0;
    #0.5;
    checks++;
    if (datA !== 8'h00) begin
      errors++; $display("FAIL clr_wr_ignored: got %h expected 00", datA);
    end
  endtask

  task automatic test_swap_write();
    wr(4'd2, 8'h11);
    wr(4'd7, 8'h22);
    rd_addrA = 4'd2; rd_addrB = 4'd7; swap_en = 1'b1;
    wr_en = 1'b1; wr_addr = 4'd7; dat_in = 8'h99;
    step();
    swap_en = 1'b0; wr_en = 1'b0;
    #0.5;
    checks++;
    if (datA !== 8'h22) begin
      errors++; $display("FAIL swapwr_A2: got %h expected 22", datA);
    end
    checks++;
    if (datB !== 8'h99) begin
      errors++; $display("FAIL swapwr_B7: got %h expected 99", datB);
    end
  endtask

  task automatic test_reset_mid_clear();
    wr(4'd10, 8'hAA);
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    for (int i = 0; i < 6; i++) step();
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL midclr_busy: got %b expected 0", busy);
    end
    rd_addrA = 4'd10;
    #0.5;
    checks++;
    if (datA !== 8'h00) begin
      errors++; $display("FAIL midclr_entry10: got %h expected 00", datA);
    end
    @(negedge clk);
    rst_n = 1'b1;
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL midclr_restart: got %b expected 1", busy);
    end
    for (int i = 0; i < 16; i++) step();
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL midclr_restart_end: got %b expected 0", busy);
    end
  endtask

  task automatic test_bypass_zero();
    logic [7:0] exp_fwd;
    wr(4'd4, 8'h11);
`ifdef REG_FILE_BYPASS_EN
    exp_fwd = 8'h5A;
`else
    exp_fwd = 8'h11;
`endif
    rd_addrA = 4'd4;
    wr_en = 1'b1; wr_addr = 4'd4; dat_in = 8'h5A;
    #0.5;
    checks++;
    if (datA !== exp_fwd) begin
      errors++; $display("FAIL fwd_same_cycle: got %h expected %h", datA, exp_fwd);
    end
    step();
    wr_en = 1'b0;
    #0.5;
    checks++;
    if (datA !== 8'h5A) begin
      errors++; $display("FAIL fwd_after_edge: got %h expected 5A", datA);
    end
    // hard-wired zero entry
    rd_addrA = 4'd0;
    wr_en = 1'b1; wr_addr = 4'd0; dat_in = 8'h5A;
    #0.5;
    checks++;
    if (zdatA !== 8'h00) begin
      errors++; $display("FAIL zreg_wr0_now: got %h expected 00", zdatA);
    end
    step();
    wr_en = 1'b0;
    #0.5;
    checks++;
    if (zdatA !== 8'h00) begin
      errors++; $display("FAIL zreg_wr0_after: got %h expected 00", zdatA);
    end
    checks++;
    if (datA !== 8'h5A) begin
      errors++; $display("FAIL nozreg_wr0: got %h expected 5A", datA);
    end
    wr(4'd6, 8'h33);
    rd_addrA = 4'd0; rd_addrB = 4'd6; swap_en = 1'b1;
    step();
    swap_en = 1'b0;
    #0.5;
    checks++;
    if (zdatB !== 8'h00) begin
      errors++; $display("FAIL zreg_swap6: got %h expected 00", zdatB);
    end
    checks++;
    if (zdatA !== 8'h00) begin
      errors++; $display("FAIL zreg_swap0: got %h expected 00", zdatA);
    end
    checks++;
    if (datA !== 8'h33 || datB !== 8'h5A) begin
      errors++; $display("FAIL nozreg_swap: got %h/%h expected 33/5A", datA, datB);
    end
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; swap_en = 1'b0; clr_req = 1'b0;
    wr_addr = '0; rd_addrA = '0; rd_addrB = '0; dat_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    test_reset();
    test_write_swap();
    test_clear();
    test_swap_write();
    test_reset_mid_clear();
    test_bypass_zero();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
